// File: rtl/gpio_filt_pkg.sv
// Shared constants and helpers for the GPIO input conditioning stage.
package gpio_filt_pkg;

  localparam int GPIO_W = 32;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gpio_filt_bit.sv
// One pad bit: synchronizer, tick-qualified debounce counter and edge pulses.
module gpio_filt_bit
  import gpio_filt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_LEN      = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic pad,
  input  logic filt_en,
  input  logic tick,
  output logic din,
  output logic rise,
  output logic fall
);

  localparam int            CW      = cnt_width(DB_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic                   din_nxt;
  logic                   en_q;

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_comb begin
    cnt_nxt = cnt;
    din_nxt = din;
    // A change of filter mode only restarts the count; the level is kept.
    if (filt_en != en_q) begin
      cnt_nxt = '0;
    end else if (!filt_en) begin
      din_nxt = sync_q;
      cnt_nxt = '0;
    end else if (sync_q == din) begin
      cnt_nxt = '0;
    end else if (tick) begin
      if (cnt == CNT_MAX) begin
        din_nxt = sync_q;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_r <= '0;
      cnt    <= '0;
      din    <= 1'b0;
      en_q   <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pad};
      cnt    <= cnt_nxt;
      din    <= din_nxt;
      en_q   <= filt_en;
      rise   <= din_nxt & ~din;
      fall   <= ~din_nxt & din;
    end
  end

endmodule

// File: rtl/gpio_in_filter.sv
// Input conditioning in front of gpioi_din: shared sample prescaler plus
// NBITS per-bit synchronize/debounce/edge-detect slices.
module gpio_in_filter
  import gpio_filt_pkg::*;
#(
  parameter int NBITS       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PRESC       = 1,
  parameter int DB_LEN      = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [GPIO_W-1:0] pad_i,
  input  logic [GPIO_W-1:0] filt_en_i,
  output logic [GPIO_W-1:0] din_o,
  output logic [GPIO_W-1:0] rise_o,
  output logic [GPIO_W-1:0] fall_o,
  output logic              tick_o
);

  localparam int            PW    = cnt_width(PRESC);
  localparam logic [PW-1:0] P_MAX = PW'(PRESC - 1);

  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;

  assign pcnt_nxt = (pcnt == P_MAX) ? '0 : pcnt + 1'b1;

  // Tick is registered so it is low in reset yet high exactly while pcnt == P_MAX.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcnt   <= '0;
      tick_o <= 1'b0;
    end else begin
      pcnt   <= pcnt_nxt;
      tick_o <= (pcnt_nxt == P_MAX);
    end
  end

  for (genvar i = 0; i < GPIO_W; i++) begin : g_bit
    if (i < NBITS) begin : g_act
      gpio_filt_bit #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_LEN      (DB_LEN)
      ) u_bit (
        .clk     (clk),
        .rstn    (rstn),
        .pad     (pad_i[i]),
        .filt_en (filt_en_i[i]),
        .tick    (tick_o),
        .din     (din_o[i]),
        .rise    (rise_o[i]),
        .fall    (fall_o[i])
      );
    end else begin : g_tie
      logic unused_in;
      assign unused_in = pad_i[i] ^ filt_en_i[i];
      assign din_o[i]  = 1'b0;
      assign rise_o[i] = 1'b0;
      assign fall_o[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Bench for gpio_in_filter: directed scenarios plus random pad activity,
// checked against a sample-window reference model.
module tb_gpio_in_filter;

  localparam int DB = 3;
  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pad = '0, en = '0, pad4 = '0;
  logic [31:0] en4 = 32'hFF;
  logic [31:0] din, rise, fall, din4, rise4, fall4;
  logic        tick, tick4;

  int total = 0;
  int bad   = 0;

  // reference model state: hist[k] = pad sampled k edges ago
  logic [31:0] hist[8];
  logic [31:0] m_din = '0, m_rise = '0, m_fall = '0, prev_en = '0;
  int          ecount = 0;
  int          last_evt[NB];

  always #5 clk = ~clk;

  gpio_in_filter #(.NBITS(8), .SYNC_STAGES(2), .PRESC(1), .DB_LEN(3)) u_dut (
    .clk(clk), .rstn(rstn), .pad_i(pad), .filt_en_i(en),
    .din_o(din), .rise_o(rise), .fall_o(fall), .tick_o(tick)
  );

  gpio_in_filter #(.NBITS(8), .SYNC_STAGES(2), .PRESC(4), .DB_LEN(3)) u_dut4 (
    .clk(clk), .rstn(rstn), .pad_i(pad4), .filt_en_i(en4),
    .din_o(din4), .rise_o(rise4), .fall_o(fall4), .tick_o(tick4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // New level accepted once the last DB synchronized samples all disagree
  // with the held level and no mode change/acceptance happened in that window.
  task automatic model_edge();
    logic [31:0] old;
    if (!rstn) begin
      for (int k = 0; k < 8; k++) hist[k] = '0;
      m_din = '0; m_rise = '0; m_fall = '0; prev_en = '0; ecount = 0;
      for (int i = 0; i < NB; i++) last_evt[i] = 0;
      return;
    end
    ecount++;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = pad;
    old = m_din;
    for (int i = 0; i < NB; i++) begin
      bit ok;
      if (en[i] != prev_en[i]) begin
        last_evt[i] = ecount;
      end else if (!en[i]) begin
        m_din[i] = hist[2][i];
      end else if (ecount - last_evt[i] >= DB) begin
        ok = 1'b1;
        for (int j = 0; j < DB; j++) if (hist[2+j][i] == old[i]) ok = 1'b0;
        if (ok) begin
          m_din[i]    = ~old[i];
          last_evt[i] = ecount;
        end
      end
    end
    prev_en = en;
    m_rise  = m_din & ~old;
    m_fall  = ~m_din & old;
  endtask

  task automatic step(input logic [31:0] p, input string tag);
    pad = p;
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_din"},  din,  m_din);
    chk({tag, "_rise"}, rise, m_rise);
    chk({tag, "_fall"}, fall, m_fall);
    chk({tag, "_tick"}, {31'b0, tick}, {31'b0, rstn});
  endtask

  initial begin
    int n, pc, rc, fc;
    logic [31:0] p;
    for (int k = 0; k < 8; k++) hist[k] = '0;
    for (int i = 0; i < NB; i++) last_evt[i] = 0;
    en = 32'hFF;
    for (int k = 0; k < 3; k++) step(32'h0, "rst");
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) step(32'h0, "idle");

    // PRESC=4 tick period and latency window
    n = 0;
    while (!tick4 && n < 10) begin step(32'h0, "t3"); n++; end
    chk("t3_tick_seen", {31'b0, tick4}, 32'h1);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin step(32'h0, "t3"); n++; end while (!tick4 && n < 10);
      chk("t3_tick_period", n, 4);
    end
    pad4 = 32'h2; n = 0; pc = 0;
    while (!din4[1] && n < 20) begin step(32'h0, "t3"); n++; pc += int'(rise4[1]); end
    chk("t3_rise_window", {31'b0, (n >= 11 && n <= 14)}, 32'h1);
    for (int k = 0; k < 3; k++) begin step(32'h0, "t3"); pc += int'(rise4[1]); end
    chk("t3_rise_pulses", pc, 1);
    chk("t3_din4_hi", din4, 32'h2);
    pad4 = 32'h0; n = 0; pc = 0;
    while (din4[1] && n < 20) begin step(32'h0, "t3"); n++; pc += int'(fall4[1]); end
    chk("t3_fall_window", {31'b0, (n >= 11 && n <= 14)}, 32'h1);
    for (int k = 0; k < 3; k++) begin step(32'h0, "t3"); pc += int'(fall4[1]); end
    chk("t3_fall_pulses", pc, 1);
    chk("t3_din4_lo", din4, 32'h0);

    // exact filtered latency
    pc = 0;
    for (int k = 1; k <= 6; k++) begin
      step(32'h1, "t1");
      chk("t1_din0", {31'b0, din[0]}, {31'b0, (k >= 5)});
      pc += int'(rise[0]);
    end
    for (int k = 0; k < 3; k++) begin step(32'h1, "t1"); pc += int'(rise[0]); end
    chk("t1_rise_pulses", pc, 1);
    chk("t1_din", din, 32'h1);

    // glitch rejection
    step(32'h9, "t2"); step(32'h9, "t2");
    for (int k = 0; k < 6; k++) begin
      step(32'h1, "t2");
      chk("t2_din", din, 32'h1);
    end

    // bypass
    en = 32'h0;
    for (int k = 0; k < 3; k++) step(32'h1, "t4");
    rc = 0; fc = 0;
    for (int k = 1; k <= 8; k++) begin
      step((k <= 3) ? 32'h21 : 32'h1, "t4");
      chk("t4_din5", {31'b0, din[5]}, {31'b0, (k >= 3 && k <= 5)});
      rc += int'(rise[5]); fc += int'(fall[5]);
    end
    chk("t4_rise_pulses", rc, 1);
    chk("t4_fall_pulses", fc, 1);

    // inactive upper bits
    en = 32'hFF;
    for (int k = 0; k < 6; k++) step(32'h0, "t5");
    for (int k = 0; k < 8; k++) begin
      step(32'hFFFF_FF00, "t5");
      chk("t5_din", din, 32'h0);
      chk("t5_edges", rise | fall, 32'h0);
    end

    // reset mid-run
    for (int k = 0; k < 6; k++) step(32'hFF, "t6");
    chk("t6_din_pre", din, 32'hFF);
    rstn = 1'b0;
    #1;
    chk("t6_async_din", din, 32'h0);
    chk("t6_async_tick4", {31'b0, tick4}, 32'h0);
    step(32'hFF, "t6"); step(32'hFF, "t6");
    rstn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(32'hFF, "t6");
      chk("t6_din", din, (k >= 5) ? 32'hFF : 32'h0);
      chk("t6_rise", rise, (k == 5) ? 32'hFF : 32'h0);
    end

    // random activity, occasional mode changes and one reset
    p = 32'hFF;
    for (int k = 0; k < 600; k++) begin
      if (k % 64 == 0) en = $urandom;
      if (k == 300) rstn = 1'b0;
      if (k == 302) rstn = 1'b1;
      p = p ^ ($urandom & $urandom & $urandom);
      step(p, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
